// File: rtl/game_pkg.sv
// Shared game-state encoding for the input front-end and the game controller,
// plus key lane indices used by the input front-end.
package game_pkg;

  typedef enum logic [1:0] {
    STATE_START = 2'b00,
    STATE_PLAY  = 2'b01,
    STATE_OVER  = 2'b10
  } game_state_t;

  localparam int NUM_KEYS  = 4;
  localparam int NUM_DIRS  = 3;
  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_START = 3;

endpackage

// File: rtl/key_debounce.sv
// One key lane: 2-FF synchronizer, stability counter, debounced pressed level
// and a registered one-cycle press event on the released->pressed flip.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q, level_q, press_q;
  logic [CW-1:0] cnt_q;
  logic          pressed_d;

  assign pressed_d = ~sync2_q;

  // A change of the synced level while it differs from level_q makes it equal
  // again, so the equality test alone restarts the count on any bounce.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (pressed_d == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level_q <= pressed_d;
        press_q <= pressed_d;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/game_input_ctrl.sv
// Button front-end and START/PLAY/OVER state machine for the block game.
// Optional hold-to-repeat on left/right/down is enabled by KEY_AUTO_REPEAT_EN.
module game_input_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic       key_left_n,
  input  logic       key_right_n,
  input  logic       key_down_n,
  input  logic       key_start_n,
  input  logic       game_over,
  output logic [1:0] game_state,
  output logic       left_key_press,
  output logic       right_key_press,
  output logic       down_key_press,
  output logic [3:0] key_level
);

  logic [NUM_KEYS-1:0] keys_n, level, press;
  logic [NUM_DIRS-1:0] fire, pulse_q;
  game_state_t         state_q;
  logic                game_over_q;

  assign keys_n = {key_start_n, key_down_n, key_right_n, key_left_n};

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key [NUM_KEYS-1:0] (
    .clk_i   (CLK_50M),
    .rst_i   (RST),
    .key_n_i (keys_n),
    .level_o (level),
    .press_o (press)
  );

`ifdef KEY_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [NUM_DIRS-1:0][RW-1:0] rcnt_q;
  logic [NUM_DIRS-1:0]         ract_q, rfirst_q, rep;

  always_comb begin
    rep = '0;
    for (int i = 0; i < NUM_DIRS; i++)
      rep[i] = ract_q[i] && level[i] && (state_q == STATE_PLAY) &&
               (rfirst_q[i] ? (rcnt_q[i] == RW'(REPEAT_DELAY - 1))
                            : (rcnt_q[i] == RW'(REPEAT_PERIOD - 1)));
  end

  // Repeat arms only on a press accepted in PLAY; release or leaving PLAY disarms.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      rcnt_q   <= '0;
      ract_q   <= '0;
      rfirst_q <= '1;
    end else begin
      for (int i = 0; i < NUM_DIRS; i++) begin
        if (press[i] && state_q == STATE_PLAY) begin
          ract_q[i]   <= 1'b1;
          rfirst_q[i] <= 1'b1;
          rcnt_q[i]   <= '0;
        end else if (!ract_q[i] || !level[i] || state_q != STATE_PLAY) begin
          ract_q[i]   <= 1'b0;
          rfirst_q[i] <= 1'b1;
          rcnt_q[i]   <= '0;
        end else if (rep[i]) begin
          rfirst_q[i] <= 1'b0;
          rcnt_q[i]   <= '0;
        end else begin
          rcnt_q[i] <= rcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign fire = press[NUM_DIRS-1:0] | rep;
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign fire = press[NUM_DIRS-1:0];
`endif

  // Pulse gating looks at the state before the edge, so the press that enters
  // PLAY is never forwarded as a direction.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_q     <= STATE_START;
      game_over_q <= 1'b0;
      pulse_q     <= '0;
    end else begin
      game_over_q <= game_over;
      pulse_q     <= (state_q == STATE_PLAY) ? fire : '0;
      case (state_q)
        STATE_START: if (press[KEY_START]) state_q <= STATE_PLAY;
        STATE_PLAY:  if (game_over_q)      state_q <= STATE_OVER;
        STATE_OVER:  if (press[KEY_START]) state_q <= STATE_START;
        default:                           state_q <= STATE_START;
      endcase
    end
  end

  assign game_state      = state_q;
  assign left_key_press  = pulse_q[KEY_LEFT];
  assign right_key_press = pulse_q[KEY_RIGHT];
  assign down_key_press  = pulse_q[KEY_DOWN];
  assign key_level       = level;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Directed bench for game_input_ctrl with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. Inputs change #1 after a rising edge; outputs read there too.
module tb_game_input_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kl_n = 1'b1, kr_n = 1'b1, kd_n = 1'b1, ks_n = 1'b1;
  logic       gover = 1'b0;
  logic [1:0] gstate;
  logic       lp, rp, dp;
  logic [3:0] klev;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  game_input_ctrl #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
    .CLK_50M         (clk),
    .RST             (rst),
    .key_left_n      (kl_n),
    .key_right_n     (kr_n),
    .key_down_n      (kd_n),
    .key_start_n     (ks_n),
    .game_over       (gover),
    .game_state      (gstate),
    .left_key_press  (lp),
    .right_key_press (rp),
    .down_key_press  (dp),
    .key_level       (klev)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    kl_n = 1'b0; kr_n = 1'b0; kd_n = 1'b0; rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      tests++;
      if ({gstate, lp, rp, dp, klev} !== 9'd0) begin
        fails++;
        $display("FAIL reset_outputs cyc%0d: state=%b l/r/d=%b%b%b level=%b, want all 0", k, gstate, lp, rp, dp, klev);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      tests++;
      if (klev !== ((k >= 6) ? 4'b0111 : 4'b0000) || {lp, rp, dp} !== 3'b000 || gstate !== 2'b00) begin
        fails++;
        $display("FAIL reset_release cyc%0d: level=%b l/r/d=%b%b%b state=%b, want level=%b no pulse state=00",
                 k, klev, lp, rp, dp, gstate, (k >= 6) ? 4'b0111 : 4'b0000);
      end
    end
    kl_n = 1'b1; kr_n = 1'b1; kd_n = 1'b1;
    repeat (8) step();
    tests++;
    if (klev !== 4'b0000) begin
      fails++;
      $display("FAIL reset_keys_released: level=%b, want 0000", klev);
    end
  endtask

  task automatic press_start(input logic [1:0] from, input logic [1:0] to);
    ks_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      tests++;
      if (gstate !== ((k >= 7) ? to : from) || {lp, rp, dp} !== 3'b000) begin
        fails++;
        $display("FAIL start_press cyc%0d: state=%b l/r/d=%b%b%b, want state=%b no pulse",
                 k, gstate, lp, rp, dp, (k >= 7) ? to : from);
      end
    end
    ks_n = 1'b1;
    repeat (8) step();
  endtask

  task automatic test_start();
    press_start(2'b00, 2'b01);
    tests++;
    if (gstate !== 2'b01 || klev !== 4'b0000) begin
      fails++;
      $display("FAIL start_release: state=%b level=%b, want 01 / 0000", gstate, klev);
    end
  endtask

  task automatic test_clean_press();
    kd_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      tests++;
      if (dp !== (k == 7) || {lp, rp} !== 2'b00 || klev[2] !== (k >= 6)) begin
        fails++;
        $display("FAIL down_press cyc%0d: down=%b l/r=%b%b level=%b, want down=%b level2=%b",
                 k, dp, lp, rp, klev, (k == 7), (k >= 6));
      end
    end
    kd_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      tests++;
      if ({lp, rp, dp} !== 3'b000) begin
        fails++;
        $display("FAIL down_release cyc%0d: l/r/d=%b%b%b, want 000", k, lp, rp, dp);
      end
    end
    kd_n = 1'b0;
    repeat (3) step();
    kd_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      tests++;
      if ({lp, rp, dp} !== 3'b000 || klev !== 4'b0000) begin
        fails++;
        $display("FAIL glitch cyc%0d: l/r/d=%b%b%b level=%b, want no pulse level 0000", k, lp, rp, dp, klev);
      end
    end
  endtask

  task automatic test_simultaneous();
    kl_n = 1'b0; kr_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      tests++;
      if (lp !== (k == 7) || rp !== (k == 7) || dp !== 1'b0) begin
        fails++;
        $display("FAIL simultaneous cyc%0d: l/r/d=%b%b%b, want %b%b0", k, lp, rp, dp, (k == 7), (k == 7));
      end
    end
    kl_n = 1'b1; kr_n = 1'b1;
    repeat (8) step();
  endtask

  task automatic idle_press(input string tag);
    kl_n = 1'b0; kd_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      tests++;
      if ({lp, rp, dp} !== 3'b000) begin
        fails++;
        $display("FAIL %s cyc%0d: l/r/d=%b%b%b, want 000", tag, k, lp, rp, dp);
      end
    end
    kl_n = 1'b1; kd_n = 1'b1;
    repeat (8) step();
  endtask

  task automatic test_game_over();
    gover = 1'b1;
    step();
    gover = 1'b0;
    step();
    tests++;
    if (gstate !== 2'b10) begin
      fails++;
      $display("FAIL game_over: state=%b, want 10", gstate);
    end
    idle_press("press_in_over");
    tests++;
    if (gstate !== 2'b10) begin
      fails++;
      $display("FAIL over_hold: state=%b, want 10", gstate);
    end
    press_start(2'b10, 2'b00);
    idle_press("press_in_start");
    gover = 1'b1;
    step();
    gover = 1'b0;
    repeat (3) step();
    tests++;
    if (gstate !== 2'b00) begin
      fails++;
      $display("FAIL over_in_start: state=%b, want 00", gstate);
    end
    press_start(2'b00, 2'b01);
  endtask

  task automatic test_auto_repeat();
    logic exp;
    kl_n = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      step();
`ifdef KEY_AUTO_REPEAT_EN
      exp = (k == 7) || (k == 27) || (k == 35) || (k == 43) || (k == 51) || (k == 59);
`else
      exp = (k == 7);
`endif
      tests++;
      if (lp !== exp || {rp, dp} !== 2'b00) begin
        fails++;
        $display("FAIL hold_left cyc%0d: l/r/d=%b%b%b, want %b00", k, lp, rp, dp, exp);
      end
    end
    kl_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      tests++;
      if ({lp, rp, dp} !== 3'b000) begin
        fails++;
        $display("FAIL hold_release cyc%0d: l/r/d=%b%b%b, want 000", k, lp, rp, dp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_clean_press();
    test_simultaneous();
    test_game_over();
    test_auto_repeat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_input_ctrl.md
# game_input_ctrl

Input front-end for the block-game core. Conditions four raw active-low push-buttons (left, right, down, start) into one-cycle press pulses. Owns the game-state machine (START/PLAY/OVER) and drives `game_state` and the three direction pulses into the game controller, which returns `game_over`.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a key level change (20 ms at 50 MHz); legal range ≥ 2.
- `REPEAT_DELAY`, default 25_000_000: hold time before the first auto-repeat pulse (only with `KEY_AUTO_REPEAT_EN`).
- `REPEAT_PERIOD`, default 5_000_000: interval between subsequent auto-repeat pulses (only with `KEY_AUTO_REPEAT_EN`).
- `CLK_50M`  in  1  the single system clock.
- `RST`  in  1  reset, synchronous and active-high.
- `key_left_n`, `key_right_n`, `key_down_n`, `key_start_n`  in  1 each  raw, asynchronous buttons; 0 means pressed.
- `game_over`  in  1  level from the game controller; 1 means the board is lost.
- `game_state`  out  2  00 = START, 01 = PLAY, 10 = OVER; 11 is never driven.
- `left_key_press`, `right_key_press`, `down_key_press`  out  1 each  one-cycle press pulses.
- `key_level`  out  4  debounced pressed levels as {start, down, right, left}, for debug/LEDs.

## Operation
- **Per-key pipeline** (4 identical lanes):
  - 2-FF synchronizer.
  - Stability counter: cleared whenever the synced level equals the debounced level or changes; increments otherwise.
  - When the counter reaches `DEBOUNCE_CYCLES-1`, the debounced level flips and the counter clears.
  - The counter never exceeds `DEBOUNCE_CYCLES-1`.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- **Press event:** a debounced released→pressed transition. A release generates nothing.
- **Direction pulses:**
  - Asserted for exactly one cycle on a press event, and only while `game_state`=PLAY.
  - Events in START or OVER are discarded, not queued.
  - Simultaneous events on several keys give simultaneous pulses. Prioritising them is the consumer's job.
- **State machine** (registered):
  - START → PLAY on a start press event.
  - PLAY → OVER when `game_over`=1. This is checked before the start event; a start press in PLAY is ignored.
  - OVER → START on a start press event.
  - There are no other transitions.
  - Code 11 is unreachable. If it is ever entered, the machine goes to START on the next cycle.
- **Start key in PLAY:** has no effect.

## Timing
- **Reset values:**
  - `game_state`=START.
  - All press outputs 0 and `key_level`=0.
  - Synchronizer flops = 1 (released), debounced levels released, all counters 0.
  - Reset asserted mid-debounce or mid-repeat discards all progress. Only a full `DEBOUNCE_CYCLES` of stability after `RST` deasserts can produce an event.
- **Press latency:**
  - Let raw low first be sampled at edge N.
  - The debounced level goes high at edge N+1+`DEBOUNCE_CYCLES`.
  - The pulse is high for the cycle after edge N+2+`DEBOUNCE_CYCLES`.
- **Glitch rejection:** a glitch shorter than `DEBOUNCE_CYCLES` cycles (as seen after sync) never changes the debounced level.
- **State-change latency:** `game_state` changes on the same edge that registers the start pulse, i.e. the same latency as a direction pulse.
- **Game over:** `game_over` seen at edge M moves the state to OVER at edge M+1.
- **Pulse gating:** uses the `game_state` value held before the edge. A press event on the edge that enters PLAY is not forwarded.

## Configuration
- **Macro `KEY_AUTO_REPEAT_EN`, defined:**
  - Left, right and down get a hold-repeat counter, reset on the press event.
  - While the key stays debounced-pressed in PLAY, an extra pulse fires after `REPEAT_DELAY` cycles, then every `REPEAT_PERIOD` cycles.
  - Release, leaving PLAY, or `RST` stops the repeat and clears its counter.
  - Start never repeats.
- **Macro `KEY_AUTO_REPEAT_EN`, undefined:**
  - The repeat logic and the `REPEAT_*` parameters have no effect.
  - Exactly one pulse per press.

## Structure
- **Shared package `game_pkg`:**
  - The state constants `STATE_START`=2'b00, `STATE_PLAY`=2'b01, `STATE_OVER`=2'b10.
  - The 2-bit state typedef.
  - These are shared with the game controller, which must stop redefining them locally.
- **Sub-module `key_debounce`:**
  - Holds one synchronizer, one stability counter, the debounced level and the press-event output, parameterised by `DEBOUNCE_CYCLES`.
  - Instantiated four times.
  - The state machine, gating and repeat logic stay in the top.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.
- **Reset:** `RST` high 3 cycles with keys pressed → all outputs 0 and `game_state`=00; no pulse until 4 stable cycles after release of `RST`.
- **Start:** `key_start_n` low 10 cycles in START → `game_state`=01 at edge N+6; no direction pulse.
- **Clean press in PLAY:** `key_down_n` low and held → `down_key_press` high exactly one cycle at edge N+6; no pulse on release. Same with a 3-cycle low glitch → no pulse and `key_level` unchanged.
- **Simultaneous keys:** left and right pressed on the same cycle in PLAY → both pulses on the same cycle. Any press while in START or OVER → no pulse.
- **Game over and restart:** `game_over`=1 for 1 cycle in PLAY → OVER next cycle. A start press then returns to START; a second start press goes to PLAY.
- **Auto-repeat** (`KEY_AUTO_REPEAT_EN` defined): hold `key_left_n` low 60 cycles → pulses at press+0, +20, +28, +36, +44, +52. Undefined → a single pulse.
